chacha20_block_sequencer: RTL
=============================

// Module: chacha20_block_sequencer
// PURPOSE
//  Avalon-MM slave controller that sequences one ChaCha20 keystream-block computation per software request.
//  - Launches the core with a one-cycle start pulse and tracks its done signal.
//  - Owns the 32-bit block counter and guards against a hung core with a programmable timeout.
//  - Publishes {busy, ready} on a 2-bit handshake port toward the embedded processor's PIO inputs.
//  - Sits between the Nios-side Avalon fabric and the ChaCha20 core.
// PARAMETERS
//  CNT_W       32       block counter width
//  TO_W        16       timeout counter width
//  TO_DEFAULT  1024     reset value of the timeout limit register
// PORTS
//  clk          in   1      system clock
//  reset_n      in   1      asynchronous active-low reset
//  address      in   2      register select
//  chipselect   in   1      slave select
//  write_n      in   1      active-low write strobe
//  writedata    in   32     write data
//  readdata     out  32     combinational read data; zero-extended
//  core_start   out  1      one-cycle launch pulse to ChaCha20 core
//  core_done    in   1      one-cycle completion pulse from core
//  core_counter out  CNT_W  block counter presented to core; stable while busy
//  ready_out    out  2      [0] block ready, [1] busy
//  irq          out  1      only when CHACHA_SEQ_IRQ_EN is defined
// BEHAVIOUR
//  - Write qualifier: chipselect & ~write_n.
//  - readdata = register selected by address (0 = CTRL, 1 = STATUS, 2 = COUNTER, 3 = TIMEOUT).
//  - Register map:
//    - CTRL (0): wr bit0 START (self-clearing), bit1 ACK, bit2 AUTO (sticky), bit3 ABORT; rd returns AUTO in bit2, others 0.
//    - STATUS (1): bit0 busy, bit1 done, bit2 timeout_err, bit3 wrap, bit4 irq_pend. W1C on bits 2, 3 and 4.
//    - COUNTER (2): block counter. Writes are accepted only in IDLE and are ignored otherwise.
//    - TIMEOUT (3): limit, TO_W bits. A value of 0 disables the timeout.
//  - Reset values:
//    - Outputs: core_start = 0, ready_out = 2'b00, core_counter = 0, irq = 0.
//    - Registers: AUTO = 0, all status flags = 0, TIMEOUT = TO_DEFAULT.
//    - FSM = IDLE.
//  - FSM states:
//    - IDLE:   START -> LAUNCH.
//    - LAUNCH: core_start = 1 for exactly this cycle; -> WAIT. Clear timeout counter.
//    - WAIT:   busy = 1; timeout counter increments each cycle.
//      - core_done -> HOLD; set done; counter += 1.
//      - timeout counter == limit, limit != 0, no core_done -> ERR; set timeout_err.
//      - ABORT -> IDLE; counter unchanged.
//    - HOLD:   ready_out[0] = 1.
//      - ACK clears done; -> LAUNCH if AUTO, else IDLE.
//      - START without ACK is ignored.
//    - ERR:    busy = 0, ready_out = 0.
//      - W1C of timeout_err -> IDLE.
//      - START is ignored until then.
//  - Latency:
//    - START written in cycle N -> core_start high in N+1 -> WAIT in N+2.
//    - core_done in cycle M -> ready_out[0] and incremented counter visible in M+1.
//  - Boundaries:
//    - core_done in the same cycle as timeout expiry: done wins, no error.
//    - ABORT in the same cycle as core_done: done wins.
//    - core_done outside WAIT is ignored.
//    - START while busy, ACK while not done: ignored.
//    - START and ACK in the same write during HOLD: treated as ACK only.
//    - Counter all-ones + done wraps to 0 and sets the wrap flag.
//    - ready_out[1] = (state == LAUNCH or WAIT).
//    - reset_n low mid-operation returns all state to reset values immediately; no core_start is emitted.
// CONFIGURATION
//  - CHACHA_SEQ_IRQ_EN defined:
//    - irq_pend is set on entry to HOLD or ERR.
//    - irq = irq_pend; cleared by W1C of STATUS bit4.
//    - CTRL bit4 is the irq mask (rd/wr, reset 0); irq = irq_pend & mask.
//  - CHACHA_SEQ_IRQ_EN undefined:
//    - No irq port, no pending or mask logic.
//    - STATUS bit4 and CTRL bit4 read as 0.
// TESTING
//  - Single block:
//    - Stimulus: COUNTER = 5, START; core_done 10 cycles after core_start.
//    - Response: one core_start pulse; ready_out 2'b10 then 2'b01; COUNTER reads 6; ACK -> ready_out 2'b00.
//  - AUTO mode:
//    - Stimulus: AUTO = 1, START; three done/ACK pairs.
//    - Response: three core_start pulses, each exactly 1 cycle after ACK; COUNTER advances by 3.
//  - Timeout:
//    - Stimulus: TIMEOUT = 4, START; no core_done.
//    - Response: ERR after 4 WAIT cycles; STATUS = 0x4; START ignored; W1C bit2 -> IDLE.
//  - Races:
//    - Stimulus: core_done on the expiry cycle; ABORT and core_done together.
//    - Response: HOLD both times, no timeout_err; COUNTER write during WAIT ignored.
//  - Wrap:
//    - Stimulus: COUNTER = 32'hFFFFFFFF, one block.
//    - Response: COUNTER = 0, STATUS.wrap = 1.
//  - Reset and IRQ:
//    - Stimulus: reset_n low during WAIT; IRQ_EN build with mask = 1.
//    - Response: reset yields all-zero outputs. In the IRQ_EN build, irq rises one cycle after HOLD entry and W1C clears it.

Source files
------------

// File: rtl/chacha20_block_sequencer.sv
// ChaCha20 block sequencer: Avalon-MM control of one keystream block per request.
// Optional interrupt logic is built when CHACHA_SEQ_IRQ_EN is defined.
module chacha20_block_sequencer #(
  parameter int CNT_W      = 32,
  parameter int TO_W       = 16,
  parameter int TO_DEFAULT = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             core_start,
  input  logic             core_done,
  output logic [CNT_W-1:0] core_counter,
`ifdef CHACHA_SEQ_IRQ_EN
  output logic             irq,
`endif
  output logic [1:0]       ready_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_HOLD,
    S_ERR
  } state_t;

  state_t state, nxt;

  logic [CNT_W-1:0] ctr;
  logic [TO_W-1:0]  to_cnt;
  logic [TO_W-1:0]  limit;
  logic [TO_W:0]    to_nxt;
  logic             auto_q;
  logic             done_f;
  logic             terr_f;
  logic             wrap_f;
  logic             busy;
  logic             to_hit;
  logic             done_evt;
  logic             to_evt;

  logic wr, wr_ctrl, wr_stat, wr_cnt, wr_to;
  logic start_w, ack_w, abort_w;

  assign wr      = chipselect & ~write_n;
  assign wr_ctrl = wr && (address == 2'd0);
  assign wr_stat = wr && (address == 2'd1);
  assign wr_cnt  = wr && (address == 2'd2);
  assign wr_to   = wr && (address == 2'd3);
  assign start_w = wr_ctrl & writedata[0];
  assign ack_w   = wr_ctrl & writedata[1];
  assign abort_w = wr_ctrl & writedata[3];

  assign busy   = (state == S_LAUNCH) || (state == S_WAIT);
  assign to_nxt = {1'b0, to_cnt} + (TO_W+1)'(1);
  // Expiry lands on the limit-th WAIT cycle
  assign to_hit = (limit != '0) && (to_nxt == {1'b0, limit});

  assign core_start   = (state == S_LAUNCH);
  assign core_counter = ctr;
  assign ready_out    = {busy, state == S_HOLD};

  always_comb begin
    nxt      = state;
    done_evt = 1'b0;
    to_evt   = 1'b0;
    unique case (state)
      S_IDLE:   if (start_w) nxt = S_LAUNCH;
      S_LAUNCH: nxt = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          nxt      = S_HOLD;
          done_evt = 1'b1;
        end else if (abort_w) begin
          nxt = S_IDLE;
        end else if (to_hit) begin
          nxt    = S_ERR;
          to_evt = 1'b1;
        end
      end
      S_HOLD:   if (ack_w) nxt = auto_q ? S_LAUNCH : S_IDLE;
      S_ERR:    if (wr_stat && writedata[2]) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      ctr    <= '0;
      to_cnt <= '0;
      limit  <= TO_W'(TO_DEFAULT);
      auto_q <= 1'b0;
      done_f <= 1'b0;
      terr_f <= 1'b0;
      wrap_f <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_LAUNCH) to_cnt <= '0;
      else if (state == S_WAIT) to_cnt <= to_nxt[TO_W-1:0];
      if (done_evt) ctr <= ctr + CNT_W'(1);
      else if (wr_cnt && state == S_IDLE) ctr <= writedata[CNT_W-1:0];
      if (wr_to) limit <= writedata[TO_W-1:0];
      if (wr_ctrl) auto_q <= writedata[2];
      if (done_evt) done_f <= 1'b1;
      else if (state == S_HOLD && ack_w) done_f <= 1'b0;
      if (to_evt) terr_f <= 1'b1;
      else if (wr_stat && writedata[2]) terr_f <= 1'b0;
      if (done_evt && ctr == '1) wrap_f <= 1'b1;
      else if (wr_stat && writedata[3]) wrap_f <= 1'b0;
    end
  end

`ifdef CHACHA_SEQ_IRQ_EN
  logic mask_q, pend_f, ent_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= 1'b0;
      pend_f <= 1'b0;
      ent_q  <= 1'b0;
    end else begin
      ent_q <= (nxt != state) && (nxt == S_HOLD || nxt == S_ERR);
      if (wr_ctrl) mask_q <= writedata[4];
      if (ent_q) pend_f <= 1'b1;
      else if (wr_stat && writedata[4]) pend_f <= 1'b0;
    end
  end

  assign irq = pend_f & mask_q;
`else
  logic mask_q, pend_f;
  assign mask_q = 1'b0;
  assign pend_f = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: begin
        readdata[2] = auto_q;
        readdata[4] = mask_q;
      end
      2'd1: readdata[4:0] = {pend_f, wrap_f, terr_f, done_f, busy};
      2'd2: readdata = 32'(ctr);
      2'd3: readdata = 32'(limit);
      default: readdata = '0;
    endcase
  end

endmodule
